// File: rtl/seq_mult_hs.sv
// Sequential shift-and-add multiplier, signed/unsigned, valid/ready on both sides.
// Optional build macro MULT_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier is zero.
module seq_mult_hs #(
  parameter int XLEN = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] product,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and both are registered.

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [2*XLEN-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_neg;
  logic [2*XLEN-1:0]   r_product;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [XLEN-1:0]     w_mplier_next;
  logic [CW-1:0]       w_cnt_next;
  logic                w_last;
  logic [2*XLEN-1:0]   w_prod_final;

  // Magnitudes are XLEN-bit unsigned, so the most negative operand maps to 2^(XLEN-1) exactly.
  assign w_a_mag       = (is_signed && a[XLEN-1]) ? -a : a;
  assign w_b_mag       = (is_signed && b[XLEN-1]) ? -b : b;
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;
  assign w_cnt_next    = r_cnt - 1'b1;
  assign w_prod_final  = r_neg ? -w_acc_next : w_acc_next;

`ifdef MULT_EARLY_TERM_EN
  assign w_last = (w_cnt_next == '0) || (w_mplier_next == '0);
`else
  assign w_last = (w_cnt_next == '0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier   <= w_b_mag;
            r_neg      <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_acc      <= '0;
            r_cnt      <= CNT_INIT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_cnt    <= w_cnt_next;
          if (w_last) begin
            // Sign correction folds into the exit edge; no extra cycle.
            r_product   <= w_prod_final;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs: directed vectors, backpressure, mid-op reset, random ops.
module tb_seq_mult_hs;

  localparam int XLEN = 16;

  logic              clk;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] product;
  logic              busy;
  logic [1:0]        dbg_state;

  int vectors;
  int miscompares;
  logic [2*XLEN-1:0] exp_q[$];

  seq_mult_hs #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer multiplication of the operands as the chosen type.
  function automatic logic [2*XLEN-1:0] model_product(input logic [XLEN-1:0] x,
                                                      input logic [XLEN-1:0] y,
                                                      input logic s);
    logic signed [2*XLEN-1:0] sx;
    logic signed [2*XLEN-1:0] sy;
    logic [2*XLEN-1:0] ux;
    logic [2*XLEN-1:0] uy;
    sx = {{XLEN{x[XLEN-1]}}, x};
    sy = {{XLEN{y[XLEN-1]}}, y};
    ux = {{XLEN{1'b0}}, x};
    uy = {{XLEN{1'b0}}, y};
    if (s) return sx * sy;
    return ux * uy;
  endfunction

  function automatic int model_latency(input logic [XLEN-1:0] y, input logic s);
    int lat;
    longint mag;
    mag = (s && y[XLEN-1]) ? (longint'(1) << XLEN) - longint'(y) : longint'(y);
    lat = XLEN;
`ifdef MULT_EARLY_TERM_EN
    lat = 1;
    for (int i = 0; i < XLEN; i++)
      if (mag[i]) lat = i + 1;
`endif
    return lat;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one full transaction starting and ending at a falling edge.
  task automatic run_op(input logic [XLEN-1:0] a_in, input logic [XLEN-1:0] b_in,
                        input logic s_in, input int hold, input bit poke);
    logic [2*XLEN-1:0] held;
    int exp_lat;
    int n;
    exp_q.push_back(model_product(a_in, b_in, s_in));
    exp_lat = model_latency(b_in, s_in);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    a = a_in; b = b_in; is_signed = s_in; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = XLEN'($urandom); b = XLEN'($urandom); is_signed = 1'($urandom_range(0, 1));
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      check("in_ready_busy", 64'(in_ready), 64'(0));
      check("busy_high", 64'(busy), 64'(1));
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    held = exp_q.pop_front();
    check("product", 64'(product), 64'(held));
    check("busy_done", 64'(busy), 64'(0));
    check("in_ready_done", 64'(in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1; a = XLEN'($urandom); b = XLEN'($urandom);
      end
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_product", 64'(product), 64'(held));
      check("hold_no_accept", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("valid_drop", 64'(out_valid), 64'(0));
    check("in_ready_back", 64'(in_ready), 64'(1));
    check("busy_idle", 64'(busy), 64'(0));
    check("product_retained", 64'(product), 64'(held));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-checked products.
    check("model_3x5", 64'(model_product(16'd3, 16'd5, 1'b0)), 64'h0F);
    run_op(16'd3, 16'd5, 1'b0, 0, 1'b0);
    check("model_m3x5", 64'(model_product(16'hFFFD, 16'd5, 1'b1)), 64'hFFFF_FFF1);
    run_op(16'hFFFD, 16'd5, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1, 1'b0);
    check("model_ffff", 64'(model_product(16'hFFFF, 16'hFFFF, 1'b0)), 64'hFFFE_0001);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op(16'd7, 16'd9, 1'b0, 5, 1'b1);
    run_op(16'd10, 16'd4, 1'b0, 0, 1'b0);
    run_op(16'd123, 16'd0, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h8000, 1'b1, 2, 1'b0);

    // Reset during BUSY cycle 8 discards the operation.
    check("in_ready_pre_rst", 64'(in_ready), 64'(1));
    a = 16'h1234; b = 16'h0FF0; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'(1));
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_product", 64'(product), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("postrst_busy", 64'(busy), 64'(0));
    run_op(16'd6, 16'd7, 1'b0, 0, 1'b0);

    // Random operations, with small multipliers mixed in.
    for (int k = 0; k < 24; k++) begin
      logic [XLEN-1:0] ra;
      logic [XLEN-1:0] rb;
      ra = XLEN'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 31)) : XLEN'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
